// File: rtl/soc_bus_pkg.sv
// Shared types and constants for the SoC bus controller: target select,
// interrupt-controller register map and fixed encodings.
package soc_bus_pkg;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_LOCAL,
        SEL_INTC,
        SEL_PERIPH,
        SEL_UNMAPPED
    } sel_e;

    // Wide enough to index up to 32 peripheral slots.
    localparam int PIDX_W = 5;

    localparam int INTC_PENDING = 0;
    localparam int INTC_MASK    = 1;
    localparam int INTC_STATUS  = 2;
    localparam int INTC_ID      = 3;
    localparam int INTC_ERR     = 4;

    localparam int          ERR_FLAG_BIT = 31;
    localparam logic [31:0] ID_NONE      = 32'hFFFF_FFFF;

endpackage

// File: rtl/soc_bus_ctrl_intc.sv
// Interrupt controller register block: edge-detected PENDING, MASK, sticky
// ERR capture, lowest-index priority encoder and the registered CPU interrupt.
module intc_regs
    import soc_bus_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int PERIPH_AW = 4,
    parameter int NUM_IRQ   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_IRQ-1:0]   irq_i,
    input  logic                 we_i,
    input  logic [PERIPH_AW-1:0] reg_addr_i,
    input  logic [NUM_IRQ-1:0]   wdata_i,
    input  logic                 err_set_i,
    input  logic [ADDR_W-1:0]    err_addr_i,
    output logic [31:0]          rdata_o,
    output logic                 interrupt_o
);

    logic [NUM_IRQ-1:0] irq_hist_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic               err_flag_q, err_flag_d;
    logic [ADDR_W-1:0]  err_addr_q, err_addr_d;
    logic               interrupt_q;
    logic [NUM_IRQ-1:0] status;
    logic [31:0]        id;

    assign status      = pending_q & mask_q;
    assign interrupt_o = interrupt_q;

    always_comb begin
        pending_d  = pending_q;
        mask_d     = mask_q;
        err_flag_d = err_flag_q;
        err_addr_d = err_addr_q;
        if (we_i && reg_addr_i == PERIPH_AW'(INTC_PENDING))
            pending_d = pending_q & ~wdata_i;
        // A new edge in the same cycle as its W1C must not be lost.
        pending_d = pending_d | (irq_i & ~irq_hist_q);
        if (we_i && reg_addr_i == PERIPH_AW'(INTC_MASK))
            mask_d = wdata_i;
        if (we_i && reg_addr_i == PERIPH_AW'(INTC_ERR)) begin
            err_flag_d = 1'b0;
            err_addr_d = '0;
        end else if (err_set_i && !err_flag_q) begin
            err_flag_d = 1'b1;
            err_addr_d = err_addr_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_hist_q  <= '0;
            pending_q   <= '0;
            mask_q      <= '0;
            err_flag_q  <= 1'b0;
            err_addr_q  <= '0;
            interrupt_q <= 1'b0;
        end else begin
            irq_hist_q  <= irq_i;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            err_flag_q  <= err_flag_d;
            err_addr_q  <= err_addr_d;
            interrupt_q <= |status;
        end
    end

    always_comb begin
        id = ID_NONE;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (status[i]) id = 32'(i);
        end
    end

    always_comb begin
        rdata_o = '0;
        case (reg_addr_i)
            PERIPH_AW'(INTC_PENDING): rdata_o = 32'(pending_q);
            PERIPH_AW'(INTC_MASK):    rdata_o = 32'(mask_q);
            PERIPH_AW'(INTC_STATUS):  rdata_o = 32'(status);
            PERIPH_AW'(INTC_ID):      rdata_o = id;
            PERIPH_AW'(INTC_ERR): begin
                rdata_o[ERR_FLAG_BIT] = err_flag_q;
                rdata_o[ADDR_W-1:0]   = err_addr_q;
            end
            default:                  rdata_o = '0;
        endcase
    end

endmodule

// File: rtl/soc_bus_ctrl.sv
// CPU-side bus controller: decodes word addresses into local memory, the
// interrupt controller and NUM_PERIPH slots, and returns read data one cycle later.
module soc_bus_ctrl
    import soc_bus_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter int LOCAL_AW   = 12,
    parameter int PERIPH_AW  = 4,
    parameter int NUM_PERIPH = 8,
    parameter int NUM_IRQ    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_ctrl_we,
    input  logic [ADDR_W-1:0]        mem_ctrl_addr,
    input  logic [31:0]              mem_ctrl_in,
    output logic [31:0]              mem_ctrl_out,
    output logic                     local_mem_we,
    output logic [LOCAL_AW-1:0]      local_mem_addr,
    output logic [31:0]              local_mem_in,
    input  logic [31:0]              local_mem_out,
    output logic [NUM_PERIPH-1:0]    p_we,
    output logic [PERIPH_AW-1:0]     p_addr,
    output logic [31:0]              p_in,
    input  logic [NUM_PERIPH*32-1:0] p_out,
    input  logic [NUM_IRQ-1:0]       irq_in,
    output logic                     interrupt
);

    localparam int                SLOT_W     = ADDR_W - PERIPH_AW;
    localparam logic [ADDR_W-1:0] LOCAL_BASE = ADDR_W'(1 << LOCAL_AW);

    sel_e              sel, sel_q;
    logic [SLOT_W-1:0] slot;
    logic [PIDX_W-1:0] pidx, pidx_q;
    logic [31:0]       intc_rdata, intc_rdata_q;
    logic              intc_we;

    always_comb begin
        slot = SLOT_W'((mem_ctrl_addr - LOCAL_BASE) >> PERIPH_AW);
        pidx = PIDX_W'(slot - SLOT_W'(1));
        if (mem_ctrl_addr < LOCAL_BASE)
            sel = SEL_LOCAL;
        else if (slot == '0)
            sel = SEL_INTC;
        else if (slot <= SLOT_W'(NUM_PERIPH))
            sel = SEL_PERIPH;
        else
            sel = SEL_UNMAPPED;
    end

    assign local_mem_addr = mem_ctrl_addr[LOCAL_AW-1:0];
    assign p_addr         = mem_ctrl_addr[PERIPH_AW-1:0];
    assign local_mem_in   = mem_ctrl_in;
    assign p_in           = mem_ctrl_in;
    assign local_mem_we   = mem_ctrl_we && (sel == SEL_LOCAL);
    assign intc_we        = mem_ctrl_we && (sel == SEL_INTC);

    always_comb begin
        p_we = '0;
        for (int k = 0; k < NUM_PERIPH; k++)
            p_we[k] = mem_ctrl_we && (sel == SEL_PERIPH) && (pidx == PIDX_W'(k));
    end

    intc_regs #(
        .ADDR_W    (ADDR_W),
        .PERIPH_AW (PERIPH_AW),
        .NUM_IRQ   (NUM_IRQ)
    ) u_intc (
        .clk         (clk),
        .rst         (rst),
        .irq_i       (irq_in),
        .we_i        (intc_we),
        .reg_addr_i  (mem_ctrl_addr[PERIPH_AW-1:0]),
        .wdata_i     (mem_ctrl_in[NUM_IRQ-1:0]),
        .err_set_i   (sel == SEL_UNMAPPED),
        .err_addr_i  (mem_ctrl_addr),
        .rdata_o     (intc_rdata),
        .interrupt_o (interrupt)
    );

    // Every cycle is a potential read; targets answer one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q        <= SEL_NONE;
            pidx_q       <= '0;
            intc_rdata_q <= '0;
        end else begin
            sel_q        <= sel;
            pidx_q       <= pidx;
            intc_rdata_q <= intc_rdata;
        end
    end

    always_comb begin
        mem_ctrl_out = '0;
        case (sel_q)
            SEL_LOCAL: mem_ctrl_out = local_mem_out;
            SEL_INTC:  mem_ctrl_out = intc_rdata_q;
            SEL_PERIPH: begin
                for (int k = 0; k < NUM_PERIPH; k++)
                    if (pidx_q == PIDX_W'(k)) mem_ctrl_out = p_out[32*k +: 32];
            end
            default:   mem_ctrl_out = '0;
        endcase
    end

endmodule

// File: tb/tb_soc_bus_ctrl.sv
// Directed bench for soc_bus_ctrl with a behavioural 1-cycle local memory.
module tb_soc_bus_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_ctrl_we;
    logic [13:0]  mem_ctrl_addr;
    logic [31:0]  mem_ctrl_in;
    logic [31:0]  mem_ctrl_out;
    logic         local_mem_we;
    logic [11:0]  local_mem_addr;
    logic [31:0]  local_mem_in;
    logic [31:0]  local_mem_out;
    logic [7:0]   p_we;
    logic [3:0]   p_addr;
    logic [31:0]  p_in;
    logic [255:0] p_out;
    logic [7:0]   irq_in;
    logic         interrupt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] lmem [0:4095];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (local_mem_we) lmem[local_mem_addr] <= local_mem_in;
        local_mem_out <= lmem[local_mem_addr];
    end

    soc_bus_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .mem_ctrl_we    (mem_ctrl_we),
        .mem_ctrl_addr  (mem_ctrl_addr),
        .mem_ctrl_in    (mem_ctrl_in),
        .mem_ctrl_out   (mem_ctrl_out),
        .local_mem_we   (local_mem_we),
        .local_mem_addr (local_mem_addr),
        .local_mem_in   (local_mem_in),
        .local_mem_out  (local_mem_out),
        .p_we           (p_we),
        .p_addr         (p_addr),
        .p_in           (p_in),
        .p_out          (p_out),
        .irq_in         (irq_in),
        .interrupt      (interrupt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [13:0] addr, input logic [31:0] data);
        mem_ctrl_we   = we;
        mem_ctrl_addr = addr;
        mem_ctrl_in   = data;
    endtask

    initial begin
        rst = 1'b1;
        irq_in = '0;
        p_out = '0;
        p_out[31:0]    = 32'h0000_0055;
        p_out[63:32]   = 32'hA5A5_0001;
        p_out[255:224] = 32'h7777_0007;
        drive(1'b0, 14'd0, 32'd0);
        #1;
        chk("reset_out", mem_ctrl_out, 32'd0);
        chk("reset_irq", {31'd0, interrupt}, 32'd0);
        tick(); tick();
        rst = 1'b0;

        // Local memory write then read
        drive(1'b1, 14'd5, 32'hDEAD_BEEF);
        #1;
        chk("lm_we", {31'd0, local_mem_we}, 32'd1);
        chk("lm_addr", {20'd0, local_mem_addr}, 32'd5);
        chk("lm_in", local_mem_in, 32'hDEAD_BEEF);
        tick();
        drive(1'b0, 14'd5, 32'd0);
        tick();
        chk("lm_read", mem_ctrl_out, 32'hDEAD_BEEF);

        // Peripheral 0 write/read
        drive(1'b1, 14'd4115, 32'h0000_0055);
        #1;
        chk("p_we", {24'd0, p_we}, 32'h01);
        chk("p_addr", {28'd0, p_addr}, 32'd3);
        chk("p_lm_we", {31'd0, local_mem_we}, 32'd0);
        tick();
        drive(1'b0, 14'd4115, 32'd0);
        tick();
        chk("p0_read", mem_ctrl_out, 32'h0000_0055);

        // Back-to-back reads across targets
        drive(1'b1, 14'd1, 32'h1111_1111); tick();
        drive(1'b1, 14'd2, 32'h2222_2222); tick();
        drive(1'b0, 14'd1, 32'd0);         tick();
        chk("b2b_local1", mem_ctrl_out, 32'h1111_1111);
        drive(1'b0, 14'd4128, 32'd0);      tick();
        chk("b2b_p1", mem_ctrl_out, 32'hA5A5_0001);
        drive(1'b0, 14'd2, 32'd0);         tick();
        chk("b2b_local2", mem_ctrl_out, 32'h2222_2222);
        drive(1'b0, 14'd4239, 32'd0);      tick();
        chk("p7_last", mem_ctrl_out, 32'h7777_0007);

        // Interrupt path
        drive(1'b1, 14'd4097, 32'h04); tick();
        drive(1'b0, 14'd0, 32'd0);
        irq_in = 8'h04;
        tick();
        chk("irq_1cyc", {31'd0, interrupt}, 32'd0);
        irq_in = 8'h00;
        tick();
        chk("irq_2cyc", {31'd0, interrupt}, 32'd1);
        drive(1'b0, 14'd4099, 32'd0); tick();
        chk("id_2", mem_ctrl_out, 32'd2);
        drive(1'b0, 14'd4098, 32'd0); tick();
        chk("status", mem_ctrl_out, 32'h04);
        drive(1'b0, 14'd4096, 32'd0); tick();
        chk("pending", mem_ctrl_out, 32'h04);
        drive(1'b1, 14'd4096, 32'h04); tick();
        drive(1'b0, 14'd0, 32'd0); tick();
        chk("w1c_irq", {31'd0, interrupt}, 32'd0);

        // Set beats W1C on the same bit
        irq_in = 8'h02; tick();
        irq_in = 8'h00; tick();
        irq_in = 8'h02;
        drive(1'b1, 14'd4096, 32'h02); tick();
        irq_in = 8'h00;
        drive(1'b0, 14'd4096, 32'd0); tick();
        chk("set_wins", mem_ctrl_out, 32'h02);
        chk("masked_irq", {31'd0, interrupt}, 32'd0);
        drive(1'b1, 14'd4097, 32'h06); tick();
        drive(1'b0, 14'd0, 32'd0); tick();
        chk("unmask_irq", {31'd0, interrupt}, 32'd1);
        drive(1'b1, 14'd4097, 32'h00); tick();
        drive(1'b0, 14'd4096, 32'd0); tick();
        chk("mask_drop", {31'd0, interrupt}, 32'd0);
        chk("mask_keeps_pend", mem_ctrl_out, 32'h02);
        drive(1'b1, 14'd4096, 32'hFF); tick();

        // Unmapped accesses and sticky ERR
        drive(1'b0, 14'd16000, 32'd0); tick();
        chk("unmapped_rd", mem_ctrl_out, 32'd0);
        drive(1'b0, 14'd4100, 32'd0); tick();
        chk("err_first", mem_ctrl_out, 32'h8000_3E80);
        drive(1'b1, 14'd16001, 32'h1234_5678);
        #1;
        chk("unmapped_wr_we", {23'd0, local_mem_we, p_we}, 32'd0);
        tick();
        drive(1'b0, 14'd4100, 32'd0); tick();
        chk("err_sticky", mem_ctrl_out, 32'h8000_3E80);
        drive(1'b1, 14'd4100, 32'd0); tick();
        drive(1'b0, 14'd4105, 32'd0); tick();
        chk("reserved_rd", mem_ctrl_out, 32'd0);
        drive(1'b0, 14'd4100, 32'd0); tick();
        chk("err_cleared", mem_ctrl_out, 32'd0);
        drive(1'b0, 14'd4240, 32'd0); tick();
        drive(1'b0, 14'd4100, 32'd0); tick();
        chk("err_above_p7", mem_ctrl_out, 32'h8000_1090);

        // Asynchronous reset mid-sequence
        drive(1'b1, 14'd4097, 32'hFF); tick();
        drive(1'b0, 14'd5, 32'd0);
        irq_in = 8'h01; tick();
        irq_in = 8'h00; tick();
        chk("pre_rst_irq", {31'd0, interrupt}, 32'd1);
        chk("pre_rst_out", mem_ctrl_out, 32'hDEAD_BEEF);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_irq", {31'd0, interrupt}, 32'd0);
        chk("rst_out", mem_ctrl_out, 32'd0);
        tick();
        rst = 1'b0;
        drive(1'b0, 14'd4097, 32'd0); tick();
        chk("rst_mask", mem_ctrl_out, 32'd0);
        drive(1'b0, 14'd4096, 32'd0); tick();
        chk("rst_pending", mem_ctrl_out, 32'd0);
        drive(1'b0, 14'd4100, 32'd0); tick();
        chk("rst_err", mem_ctrl_out, 32'd0);
        drive(1'b0, 14'd4099, 32'd0); tick();
        chk("id_none", mem_ctrl_out, 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
